// File: rtl/gol_board.sv
// Game-of-Life board: double-buffered row store with a row-serial
// next-generation engine that swaps buffers when a generation completes.
module gol_board #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3,
    parameter int WRAP    = 1,
    parameter int GENBITS = 16
) (
    input  logic               ph2,
    input  logic               reset_n,
    input  logic               we,
    input  logic [REGBITS-1:0] wa,
    input  logic [WIDTH-1:0]   wd,
    input  logic [REGBITS-1:0] ra,
    output logic [WIDTH-1:0]   rd,
    input  logic               step,
    output logic               busy,
    output logic               done,
    output logic [GENBITS-1:0] gen_count
);
    localparam int ROWS = 2 ** REGBITS;

    typedef enum logic [1:0] {IDLE, CALC, SWAP} state_t;

    state_t             state;
    logic               sel;
    logic [REGBITS-1:0] row;
    logic [WIDTH-1:0]   buf0 [ROWS];
    logic [WIDTH-1:0]   buf1 [ROWS];
    logic [WIDTH-1:0]   act  [ROWS];
    logic [WIDTH-1:0]   up, mid, dn, nxt;
    logic [WIDTH+1:0]   eu, em, ed;

    function automatic logic [WIDTH-1:0] onehot(input int i);
        logic [WIDTH-1:0] v;
        v = '0;
        v[WIDTH-1-(i % WIDTH)] = 1'b1;
        return v;
    endfunction

    // Pad a row with one guard bit on each side: the wrapped cell or a dead 0
    function automatic logic [WIDTH+1:0] widen(input logic [WIDTH-1:0] w);
        return {(WRAP != 0) & w[0], w, (WRAP != 0) & w[WIDTH-1]};
    endfunction

    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            act[i] = sel ? buf1[i] : buf0[i];
        end
    end

    assign rd = act[ra];

    always_comb begin
        mid = act[row];
        up  = act[row - REGBITS'(1)];
        dn  = act[row + REGBITS'(1)];
        if (WRAP == 0) begin
            if (row == '0) up = '0;
            if (row == REGBITS'(ROWS - 1)) dn = '0;
        end
        eu = widen(up);
        em = widen(mid);
        ed = widen(dn);
    end

    always_comb begin
        logic [3:0] cnt;
        nxt = '0;
        cnt = '0;
        for (int c = 0; c < WIDTH; c++) begin
            cnt = 4'(eu[c]) + 4'(eu[c+1]) + 4'(eu[c+2])
                + 4'(em[c]) + 4'(em[c+2])
                + 4'(ed[c]) + 4'(ed[c+1]) + 4'(ed[c+2]);
            nxt[c] = (cnt == 4'd3) | (mid[c] & (cnt == 4'd2));
        end
    end

    always_ff @(posedge ph2 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROWS; i++) begin
                buf0[i] <= onehot(i);
                buf1[i] <= '0;
            end
            sel       <= 1'b0;
            state     <= IDLE;
            row       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            gen_count <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (we) begin
                        if (sel) buf1[wa] <= wd;
                        else     buf0[wa] <= wd;
                    end
                    if (step) begin
                        state <= CALC;
                        row   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    if (sel) buf0[row] <= nxt;
                    else     buf1[row] <= nxt;
                    row <= row + REGBITS'(1);
                    if (row == REGBITS'(ROWS - 1)) state <= SWAP;
                end
                SWAP: begin
                    sel       <= ~sel;
                    gen_count <= gen_count + GENBITS'(1);
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
